// File: rtl/cpu_clk_pkg.sv
// Shared types and defaults for the CPU step controller.
// Optional macro CPU_STEP_SLOW_CLK_EN enables the divided slow_clk output.
package cpu_clk_pkg;

    localparam int DIV_W       = 4;
    localparam int DEFAULT_DIV = 3;

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_e;

endpackage

// File: rtl/phase_counter.sv
// Modulo phase counter with a live ratio and a pending ratio applied at wrap.
// With CPU_STEP_SLOW_CLK_EN defined it also produces a registered slow clock.
module phase_counter #(
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_now_i,
    input  logic             load_pend_i,
    input  logic [DIV_W-1:0] value_i,
    output logic [DIV_W-1:0] phase_o,
    output logic             wrap_o,
    output logic             slow_o
);

    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] ratio;
    logic             adv;

    // Ratios 0 and 1 both collapse to a strobe every cycle.
    assign ratio   = (div_q < DIV_W'(2)) ? DIV_W'(1) : div_q;
    assign wrap_o  = (phase_q == ratio - DIV_W'(1));
    assign adv     = en_i && !clr_i;
    assign phase_o = phase_q;

    // Next phase and ratio; a direct load supersedes anything pending.
    always_comb begin
        phase_d    = phase_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = wrap_o ? '0 : phase_q + DIV_W'(1);
        end
        if (adv && wrap_o && pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (load_pend_i) begin
            pend_d     = value_i;
            pend_vld_d = 1'b1;
        end
        if (load_now_i) begin
            div_d      = value_i;
            pend_vld_d = 1'b0;
        end
    end

    // Phase and divider state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q    <= '0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

`ifdef CPU_STEP_SLOW_CLK_EN
    logic slow_q;

    // High for the first half of each period; ratio 1 gives half 0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slow_q <= 1'b0;
        end else begin
            slow_q <= adv && (phase_q < (ratio >> 1));
        end
    end

    assign slow_o = slow_q;
`else
    assign slow_o = 1'b0;
`endif

endmodule

// File: rtl/cpu_step_controller.sv
// Run/halt/single-step sequencer producing the CPU advance strobe cpu_en.
// Optional macro CPU_STEP_SLOW_CLK_EN enables the divided slow_clk output.
module cpu_step_controller
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W       = cpu_clk_pkg::DIV_W,
    parameter int DEFAULT_DIV = cpu_clk_pkg::DEFAULT_DIV,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             div_load_i,
    input  logic [DIV_W-1:0] div_value_i,
    input  logic             run_i,
    input  logic             halt_i,
    input  logic             step_req_i,
    output logic             step_ack_o,
    output logic             cpu_en_o,
    output logic             slow_clk_o,
    output logic             busy_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    state_e           state_q, state_d;
    logic             step_armed_q, step_armed_d;
    logic             step_ack_q, step_ack_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [DIV_W-1:0] phase;
    logic             wrap;
    logic             busy;
    logic             cpu_en;
    logic             halt_load;

    assign busy      = (state_q != HALT);
    assign cpu_en    = busy && wrap && !halt_i;
    assign halt_load = !busy || halt_i;

    phase_counter #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_phase (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr_i       (halt_load),
        .en_i        (busy),
        .load_now_i  (div_load_i && halt_load),
        .load_pend_i (div_load_i && !halt_load),
        .value_i     (div_value_i),
        .phase_o     (phase),
        .wrap_o      (wrap),
        .slow_o      (slow_clk_o)
    );

    // Next state with halt > run > step_req, plus step handshake and counter.
    always_comb begin
        state_d       = state_q;
        step_armed_d  = step_armed_q;
        step_ack_d    = 1'b0;
        cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, cpu_en};
        case (state_q)
            HALT: begin
                if (halt_i)                         state_d = HALT;
                else if (run_i)                     state_d = RUN;
                else if (step_req_i && step_armed_q) state_d = STEP;
            end
            RUN: begin
                if (halt_i) state_d = HALT;
            end
            STEP: begin
                if (halt_i) begin
                    state_d = HALT;
                end else if (cpu_en) begin
                    state_d      = HALT;
                    step_ack_d   = 1'b1;
                    step_armed_d = 1'b0;
                end
            end
            default: state_d = HALT;
        endcase
        if (!step_req_i) step_armed_d = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= HALT;
            step_armed_q  <= 1'b1;
            step_ack_q    <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            step_armed_q  <= step_armed_d;
            step_ack_q    <= step_ack_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign step_ack_o    = step_ack_q;
    assign cpu_en_o      = cpu_en;
    assign busy_o        = busy;
    assign state_o       = state_q;
    assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller; a cycle model predicts outputs.
// Builds with or without CPU_STEP_SLOW_CLK_EN.
module tb_cpu_step_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_load;
    logic [3:0]  div_value;
    logic        run, halt, step_req;
    logic        step_ack, cpu_en, slow_clk, busy;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;
    int seen_en = 0;
    int seen_slow = 0;

    typedef struct packed {
        logic        en;
        logic        ack;
        logic        slow;
        logic        busy;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // model state
    logic [1:0]  m_state;
    logic [3:0]  m_phase, m_div, m_pend;
    logic        m_pvld, m_armed, m_ack, m_slow;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    cpu_step_controller dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .div_load_i    (div_load),
        .div_value_i   (div_value),
        .run_i         (run),
        .halt_i        (halt),
        .step_req_i    (step_req),
        .step_ack_o    (step_ack),
        .cpu_en_o      (cpu_en),
        .slow_clk_o    (slow_clk),
        .busy_o        (busy),
        .state_o       (state),
        .cycle_count_o (cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_eff();
        return (m_div == 4'd0 || m_div == 4'd1) ? 4'd1 : m_div;
    endfunction

    function automatic logic m_en();
        return (m_state != 2'b00) && !halt && (m_phase + 4'd1 == m_eff());
    endfunction

    task automatic model_reset();
        m_state = 2'b00; m_phase = 0; m_div = 4'd3; m_pend = 0;
        m_pvld = 0; m_armed = 1; m_ack = 0; m_slow = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic       en;
        logic [1:0] ns;
        logic       idle;
        en   = m_en();
        idle = (m_state == 2'b00);
        ns   = m_state;
        if (halt) ns = 2'b00;
        else if (idle && run) ns = 2'b01;
        else if (idle && step_req && m_armed) ns = 2'b10;
        else if (m_state == 2'b10 && en) ns = 2'b00;
`ifdef CPU_STEP_SLOW_CLK_EN
        m_slow = !idle && !halt && (m_phase < (m_eff() >> 1));
`else
        m_slow = 1'b0;
`endif
        m_ack   = (m_state == 2'b10) && en;
        if (!step_req) m_armed = 1'b1;
        else if (m_ack) m_armed = 1'b0;
        m_cnt   = m_cnt + (en ? 32'd1 : 32'd0);
        if (idle || halt) m_phase = 0;
        else m_phase = en ? 4'd0 : m_phase + 4'd1;
        if (div_load && (idle || halt)) begin
            m_div = div_value; m_pvld = 0;
        end else begin
            if (en && m_pvld) begin m_div = m_pend; m_pvld = 0; end
            if (div_load) begin m_pend = div_value; m_pvld = 1; end
        end
        m_state = ns;
    endtask

    task automatic tick();
        exp_t e;
        exp_t x;
        e.en   = m_en();
        e.ack  = m_ack;
        e.slow = m_slow;
        e.busy = (m_state != 2'b00);
        e.st   = m_state;
        e.cnt  = m_cnt;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, x.en});
        chk("step_ack", {31'd0, step_ack}, {31'd0, x.ack});
        chk("slow_clk", {31'd0, slow_clk}, {31'd0, x.slow});
        chk("busy", {31'd0, busy}, {31'd0, x.busy});
        chk("state", {30'd0, state}, {30'd0, x.st});
        chk("cycle_count", cycle_count, x.cnt);
        seen_en   += int'(cpu_en);
        seen_slow += int'(slow_clk);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        div_load = 0; div_value = 0; run = 0; halt = 0; step_req = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        model_reset();
        #1;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cnt", cycle_count, 32'd0);
        chk("rst_en", {31'd0, cpu_en}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;

        // run at default ratio 3
        run = 1; seen_en = 0;
        ticks(10);
        chk("t1_strobes", seen_en, 3);
        chk("t1_cnt", cycle_count, 32'd3);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        run = 0; halt = 1; tick(); halt = 0;

        // held step_req gives exactly one step
        step_req = 1; seen_en = 0;
        ticks(10);
        chk("t2_one_step", seen_en, 1);
        chk("t2_halted", {30'd0, state}, 32'd0);
        step_req = 0; tick();
        step_req = 1; seen_en = 0;
        ticks(6);
        chk("t2_second_step", seen_en, 1);
        step_req = 0; tick();

        // reload ratio mid-period
        run = 1; ticks(2);
        div_load = 1; div_value = 4'd5; tick();
        div_load = 0; seen_en = 0;
        tick();
        chk("t3_old_period", seen_en, 1);
        seen_en = 0;
        ticks(10);
        chk("t3_new_period", seen_en, 2);
        run = 0; halt = 1; tick(); halt = 0;

        // abort a step with halt
        div_load = 1; div_value = 4'd3; tick(); div_load = 0;
        step_req = 1; seen_en = 0;
        ticks(2);
        halt = 1; tick();
        step_req = 0; tick();
        chk("t4_no_strobe", seen_en, 0);
        chk("t4_state", {30'd0, state}, 32'd0);
        run = 1; ticks(2);
        chk("t4_halt_wins", {30'd0, state}, 32'd0);
        halt = 0; run = 0;

        // ratio 0 means every cycle
        div_load = 1; div_value = 4'd0; tick(); div_load = 0;
        run = 1; tick();
        seen_en = 0; seen_slow = 0;
        ticks(5);
        chk("t5_every_cycle", seen_en, 5);
        chk("t5_slow_div0", seen_slow, 0);
        run = 0; halt = 1; tick(); halt = 0;
        div_load = 1; div_value = 4'd4; tick(); div_load = 0;
        run = 1; tick();
        seen_slow = 0;
        ticks(8);
`ifdef CPU_STEP_SLOW_CLK_EN
        chk("t5_slow_div4", seen_slow, 4);
`else
        chk("t5_slow_div4", seen_slow, 0);
`endif

        // asynchronous reset between edges while running
        ticks(3);
        #3 reset = 1;
        #1;
        chk("t6_en", {31'd0, cpu_en}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cnt", cycle_count, 32'd0);
        chk("t6_ack", {31'd0, step_ack}, 32'd0);
        chk("t6_slow", {31'd0, slow_clk}, 32'd0);
        model_reset();
        run = 0;
        @(posedge clk);
        #1 reset = 0;
        seen_en = 0;
        ticks(5);
        chk("t6_idle", seen_en, 0);
        run = 1;
        ticks(4);
        chk("t6_div3", seen_en, 1);
        run = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
